// File: rtl/arm_mc_controller_if.sv
// rtl/arm_mc_controller_if.sv - control/datapath signal bundle for the multicycle ARM controller
interface arm_mc_controller_if;
   logic [31:12] Instr;
   logic [3:0]   ALUFlags;
   logic         PCWrite;
   logic         AdrSrc;
   logic         MemWrite;
   logic         IRWrite;
   logic [1:0]   ResultSrc;
   logic [1:0]   ALUControl;
   logic         ALUSrcA;
   logic [1:0]   ALUSrcB;
   logic [1:0]   ImmSrc;
   logic         RegWrite;
   logic [1:0]   RegSrc;
   logic [3:0]   State;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc, State
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc, State
   );
endinterface

// File: rtl/arm_mc_controller.sv
// rtl/arm_mc_controller.sv - multicycle ARM control unit: FSM, ALU decode, flags and condition check
module arm_mc_controller (
   input  logic                clk,
   input  logic                reset,
   arm_mc_controller_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI = 4'd7,
      S_ALUWB  = 4'd8, S_BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;

   logic [3:0] cond, rd;
   logic [1:0] op;
   logic [5:0] funct;
   assign cond  = bus.Instr[31:28];
   assign op    = bus.Instr[27:26];
   assign funct = bus.Instr[25:20];
   assign rd    = bus.Instr[15:12];

   // Only data-processing instructions carry an ALU command; loads/stores always write back.
   logic [1:0] alu_ctl;
   logic       no_write;
   logic [1:0] flag_w;
   always_comb begin
      alu_ctl  = 2'b00;
      no_write = 1'b0;
      flag_w   = 2'b00;
      if (op == 2'b00) begin
         case (funct[4:1])
            4'b0100: alu_ctl = 2'b00;
            4'b0010: alu_ctl = 2'b01;
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            4'b1010: begin alu_ctl = 2'b01; no_write = 1'b1; end
            default: no_write = 1'b1;
         endcase
         flag_w[1] = funct[0];
         flag_w[0] = funct[0] & ((alu_ctl == 2'b00) | (alu_ctl == 2'b01));
         if (funct[4:1] == 4'b1010) flag_w = 2'b11;
      end
   end

   logic n_f, z_f, c_f, v_f, ge, cond_ex;
   assign {n_f, z_f, c_f, v_f} = flags_q;
   assign ge = (n_f == v_f);
   always_comb begin
      case (cond)
         4'b0000: cond_ex = z_f;
         4'b0001: cond_ex = ~z_f;
         4'b0010: cond_ex = c_f;
         4'b0011: cond_ex = ~c_f;
         4'b0100: cond_ex = n_f;
         4'b0101: cond_ex = ~n_f;
         4'b0110: cond_ex = v_f;
         4'b0111: cond_ex = ~v_f;
         4'b1000: cond_ex = c_f & ~z_f;
         4'b1001: cond_ex = ~(c_f & ~z_f);
         4'b1010: cond_ex = ge;
         4'b1011: cond_ex = ~ge;
         4'b1100: cond_ex = ~z_f & ge;
         4'b1101: cond_ex = ~(~z_f & ge);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   logic ir_write, adr_src, alu_src_a, reg_w, mem_w, br, fetch_pc;
   logic [1:0] alu_src_b, result_src, alu_control;
   always_comb begin
      state_d     = S_FETCH;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = 2'b00;
      reg_w       = 1'b0;
      mem_w       = 1'b0;
      br          = 1'b0;
      fetch_pc    = 1'b0;
      case (state_q)
         S_FETCH: begin
            state_d = S_DECODE; ir_write = 1'b1; fetch_pc = 1'b1;
            alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_b = 2'b01;
            state_d   = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD:  begin adr_src = 1'b1; state_d = S_MEMWB; end
         S_MEMWB:  begin result_src = 2'b01; reg_w = 1'b1; end
         S_MEMWR:  begin adr_src = 1'b1; mem_w = 1'b1; end
         S_EXECR:  begin alu_control = alu_ctl; state_d = S_ALUWB; end
         S_EXECI:  begin alu_src_b = 2'b01; alu_control = alu_ctl; state_d = S_ALUWB; end
         S_ALUWB:  reg_w = 1'b1;
         S_BRANCH: begin alu_src_b = 2'b01; result_src = 2'b10; br = 1'b1; end
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      flags_d = flags_q;
      if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ex) begin
         if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
         if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Architectural write enables are held off for the whole reset pulse.
   assign bus.RegWrite   = ~reset & reg_w & cond_ex & ~no_write & (rd != 4'd15);
   assign bus.MemWrite   = ~reset & mem_w & cond_ex;
   assign bus.PCWrite    = ~reset & (fetch_pc | (cond_ex & (br | (reg_w & ~no_write & (rd == 4'd15)))));
   assign bus.IRWrite    = ~reset & ir_write;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = op;
   assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
   assign bus.State      = state_q;
endmodule
